// File: rtl/bram_access_ctrl_pkg.sv
// bram_access_ctrl_pkg: shared BRAM geometry, controller state encoding and address-width helper.
package bram_access_ctrl_pkg;
    localparam int BRAM_WORDS_PER_BLOCK = 256;
    localparam int BRAM_DATA_W = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    function automatic int calc_aw(input int num_blocks);
        return $clog2(BRAM_WORDS_PER_BLOCK) + $clog2(num_blocks);
    endfunction
endpackage

// File: rtl/bram_access_ctrl_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter; on contention the client not granted last wins.
module rr_arbiter2 (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic       i_enable,
    output logic [1:0] o_gnt
);
    logic r_last;

    // r_last = 1 means client 1 (B) was granted last, so client 0 (A) wins the next tie
    always_comb begin
        o_gnt[0] = i_enable & i_req[0] & (~i_req[1] | r_last);
        o_gnt[1] = i_enable & i_req[1] & (~i_req[0] | ~r_last);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_last <= 1'b1;
        else if (|o_gnt) r_last <= o_gnt[1];
    end
endmodule

// File: rtl/bram_access_ctrl.sv
// bram_access_ctrl: shares a banked BRAM between clients A and B and sweeps it to CLEAR_VALUE on reset or command.
module bram_access_ctrl
    import bram_access_ctrl_pkg::*;
#(
    parameter int                     NUM_BLOCKS     = 16,
    parameter logic [BRAM_DATA_W-1:0] CLEAR_VALUE    = 16'h0000,
    parameter bit                     CLEAR_ON_RESET = 1'b1,
    localparam int                    AW             = calc_aw(NUM_BLOCKS)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_a_req,
    input  logic                   i_a_we,
    input  logic [AW-1:0]          i_a_addr,
    input  logic [BRAM_DATA_W-1:0] i_a_wdata,
    output logic                   o_a_gnt,
    output logic                   o_a_rvalid,
    output logic [BRAM_DATA_W-1:0] o_a_rdata,
    input  logic                   i_b_req,
    input  logic                   i_b_we,
    input  logic [AW-1:0]          i_b_addr,
    input  logic [BRAM_DATA_W-1:0] i_b_wdata,
    output logic                   o_b_gnt,
    output logic                   o_b_rvalid,
    output logic [BRAM_DATA_W-1:0] o_b_rdata,
    input  logic                   i_clear_start,
    output logic                   o_busy,
    output logic                   o_clear_done,
    output logic                   o_bram_rd_en,
    output logic                   o_bram_wr_en,
    output logic [AW-1:0]          o_bram_rd_addr,
    output logic [AW-1:0]          o_bram_wr_addr,
    output logic [BRAM_DATA_W-1:0] o_bram_wdata,
    input  logic [BRAM_DATA_W-1:0] i_bram_rdata
);
    localparam logic [AW-1:0] LAST_ADDR = AW'(BRAM_WORDS_PER_BLOCK * NUM_BLOCKS - 1);

    state_t                 r_state;
    logic [AW-1:0]          r_cnt;
    logic                   r_clear_done;
    logic                   r_a_rvalid;
    logic                   r_b_rvalid;
    logic [AW-1:0]          r_rd_addr;
    logic [AW-1:0]          r_wr_addr;
    logic [BRAM_DATA_W-1:0] r_wdata;

    logic       w_clr;
    logic       w_arb_en;
    logic [1:0] w_gnt;
    logic       w_a_wr;
    logic       w_b_wr;
    logic       w_a_rd;
    logic       w_b_rd;

    rr_arbiter2 u_arb (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_req    ({i_b_req, i_a_req}),
        .i_enable (w_arb_en),
        .o_gnt    (w_gnt)
    );

    // Sweep and client mux share the BRAM write port; reset gates everything so addresses hold
    always_comb begin
        w_clr          = i_rst_n & (r_state == ST_CLEAR);
        w_arb_en       = i_rst_n & (r_state == ST_IDLE) & ~i_clear_start;
        w_a_wr         = w_gnt[0] & i_a_we;
        w_b_wr         = w_gnt[1] & i_b_we;
        w_a_rd         = w_gnt[0] & ~i_a_we;
        w_b_rd         = w_gnt[1] & ~i_b_we;
        o_a_gnt        = w_gnt[0];
        o_b_gnt        = w_gnt[1];
        o_bram_wr_en   = w_clr | w_a_wr | w_b_wr;
        o_bram_rd_en   = w_a_rd | w_b_rd;
        o_bram_wr_addr = w_clr ? r_cnt : w_a_wr ? i_a_addr : w_b_wr ? i_b_addr : r_wr_addr;
        o_bram_wdata   = w_clr ? CLEAR_VALUE : w_a_wr ? i_a_wdata : w_b_wr ? i_b_wdata : r_wdata;
        o_bram_rd_addr = w_a_rd ? i_a_addr : w_b_rd ? i_b_addr : r_rd_addr;
        o_busy         = (r_state == ST_CLEAR);
        o_clear_done   = r_clear_done;
        o_a_rvalid     = r_a_rvalid;
        o_b_rvalid     = r_b_rvalid;
        o_a_rdata      = i_bram_rdata;
        o_b_rdata      = i_bram_rdata;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            r_cnt        <= '0;
            r_clear_done <= 1'b0;
            r_a_rvalid   <= 1'b0;
            r_b_rvalid   <= 1'b0;
            r_rd_addr    <= '0;
            r_wr_addr    <= '0;
            r_wdata      <= '0;
        end else begin
            r_a_rvalid <= w_a_rd;
            r_b_rvalid <= w_b_rd;
            r_rd_addr  <= o_bram_rd_addr;
            r_wr_addr  <= o_bram_wr_addr;
            r_wdata    <= o_bram_wdata;
            if (r_state == ST_CLEAR) begin
                r_cnt        <= (r_cnt == LAST_ADDR) ? '0 : r_cnt + 1'b1;
                r_clear_done <= (r_cnt == LAST_ADDR);
                if (r_cnt == LAST_ADDR) r_state <= ST_IDLE;
            end else begin
                r_clear_done <= 1'b0;
                if (i_clear_start) r_state <= ST_CLEAR;
            end
        end
    end
endmodule

// File: tb/tb_bram_access_ctrl.sv
// tb_bram_access_ctrl: directed and random checks of bram_access_ctrl against a memory-level reference model.
module tb_bram_access_ctrl;
    localparam int          NB    = 2;
    localparam int          AW    = 9;
    localparam int          WORDS = 256 * NB;
    localparam logic [15:0] CV    = 16'h0000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_req, a_we, b_req, b_we, clear_start;
    logic [AW-1:0] a_addr, b_addr;
    logic [15:0]   a_wdata, b_wdata;
    logic          a_gnt, a_rvalid, b_gnt, b_rvalid, busy, clear_done;
    logic [15:0]   a_rdata, b_rdata;
    logic          bram_rd_en, bram_wr_en;
    logic [AW-1:0] bram_rd_addr, bram_wr_addr;
    logic [15:0]   bram_wdata, bram_rdata;

    logic [15:0] mem [WORDS];

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] exp_mem [WORDS];
    bit          m_clear, m_done, m_last, pend_a, pend_b;
    int          m_cnt;
    logic [15:0] pend_ad, pend_bd;
    logic [AW-1:0] m_lra, m_lwa;
    logic [15:0] m_lwd;
    bit          g_ga, g_gb;
    logic        o_ga, o_gb, o_busy, o_done;

    always #5 clk = ~clk;

    bram_access_ctrl #(.NUM_BLOCKS(NB), .CLEAR_VALUE(CV), .CLEAR_ON_RESET(1'b1)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_a_req(a_req), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_wdata(a_wdata),
        .o_a_gnt(a_gnt), .o_a_rvalid(a_rvalid), .o_a_rdata(a_rdata),
        .i_b_req(b_req), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
        .o_b_gnt(b_gnt), .o_b_rvalid(b_rvalid), .o_b_rdata(b_rdata),
        .i_clear_start(clear_start), .o_busy(busy), .o_clear_done(clear_done),
        .o_bram_rd_en(bram_rd_en), .o_bram_wr_en(bram_wr_en),
        .o_bram_rd_addr(bram_rd_addr), .o_bram_wr_addr(bram_wr_addr),
        .o_bram_wdata(bram_wdata), .i_bram_rdata(bram_rdata)
    );

    always @(posedge clk) begin
        if (bram_wr_en) mem[bram_wr_addr] <= bram_wdata;
        if (bram_rd_en) bram_rdata <= mem[bram_rd_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_clear = 1'b1; m_cnt = 0; m_last = 1'b1; m_done = 1'b0;
        pend_a = 1'b0; pend_b = 1'b0; m_lra = '0; m_lwa = '0; m_lwd = '0;
    endtask

    // Inputs are set by the caller just after an edge; check mid-cycle, then advance the model at the edge
    task automatic tick();
        bit ega, egb, ewr, erd;
        logic [AW-1:0] ewa, era;
        logic [15:0] ewd;
        #1;
        ega = 0; egb = 0; ewr = 0; erd = 0; ewa = m_lwa; era = m_lra; ewd = m_lwd;
        if (rst_n) begin
            if (m_clear) begin
                ewr = 1; ewa = AW'(m_cnt); ewd = CV;
            end else if (!clear_start) begin
                if (a_req && b_req) begin ega = m_last; egb = !m_last; end
                else begin ega = a_req; egb = b_req; end
                if (ega) begin
                    if (a_we) begin ewr = 1; ewa = a_addr; ewd = a_wdata; end
                    else begin erd = 1; era = a_addr; end
                end
                if (egb) begin
                    if (b_we) begin ewr = 1; ewa = b_addr; ewd = b_wdata; end
                    else begin erd = 1; era = b_addr; end
                end
            end
        end
        o_ga = a_gnt; o_gb = b_gnt; o_busy = busy; o_done = clear_done;
        chk("busy", busy, m_clear);
        chk("a_gnt", a_gnt, ega);
        chk("b_gnt", b_gnt, egb);
        chk("wr_en", bram_wr_en, ewr);
        chk("rd_en", bram_rd_en, erd);
        chk("wr_addr", bram_wr_addr, ewa);
        chk("wdata", bram_wdata, ewd);
        chk("rd_addr", bram_rd_addr, era);
        chk("a_rvalid", a_rvalid, pend_a);
        chk("b_rvalid", b_rvalid, pend_b);
        if (pend_a) chk("a_rdata", a_rdata, pend_ad);
        if (pend_b) chk("b_rdata", b_rdata, pend_bd);
        chk("clear_done", clear_done, m_done);
        g_ga = ega; g_gb = egb;
        @(posedge clk);
        if (!rst_n) model_reset();
        else begin
            pend_a = ega && !a_we; pend_ad = exp_mem[a_addr];
            pend_b = egb && !b_we; pend_bd = exp_mem[b_addr];
            if (ega || egb) m_last = egb;
            if (ega && a_we) exp_mem[a_addr] = a_wdata;
            if (egb && b_we) exp_mem[b_addr] = b_wdata;
            m_lwa = ewa; m_lra = era; m_lwd = ewd;
            if (m_clear) begin
                exp_mem[m_cnt] = CV;
                m_done = (m_cnt == WORDS - 1);
                m_clear = !m_done;
                m_cnt = (m_cnt + 1) % WORDS;
            end else begin
                m_done = 1'b0;
                if (clear_start) m_clear = 1'b1;
            end
        end
        #1;
    endtask

    task automatic a_op(input bit we, input int addr, input logic [15:0] d);
        a_req = 1; a_we = we; a_addr = AW'(addr); a_wdata = d;
        tick();
        a_req = 0;
    endtask

    initial begin
        int n, k;
        for (int i = 0; i < WORDS; i++) exp_mem[i] = CV;
        rst_n = 0; a_req = 0; b_req = 0; a_we = 0; b_we = 0; clear_start = 0;
        a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
        @(posedge clk); #1;
        model_reset();

        // Reset sweep: requests during reset must not be granted
        a_req = 1;
        tick();
        a_req = 0; rst_n = 1;
        n = 0;
        for (int i = 0; i < WORDS; i++) begin tick(); n += int'(o_busy); end
        chk("busy_cycles", n, WORDS);
        tick();
        chk("done_after_sweep", o_done, 1);
        a_op(0, 'h1FF, '0);
        tick();

        // Write then read same address in consecutive cycles
        a_op(1, 'h123, 16'hBEEF);
        a_op(0, 'h123, '0);
        tick();

        // Fresh reset, then contention: A first, alternating
        rst_n = 0; tick(); rst_n = 1;
        repeat (WORDS + 1) tick();
        a_req = 1; a_we = 0; b_req = 1; b_we = 0;
        for (int i = 0; i < 6; i++) begin
            a_addr = AW'($urandom_range(0, WORDS - 1));
            b_addr = AW'($urandom_range(0, WORDS - 1));
            tick();
            chk("alt_a", o_ga, (i % 2 == 0));
            chk("alt_b", o_gb, (i % 2 == 1));
        end
        a_req = 0; b_req = 0;
        tick();

        // Clear with B pending
        for (int i = 1; i <= 4; i++) a_op(1, i * 37, 16'h1000 + 16'(i));
        b_req = 1; b_we = 0; b_addr = AW'(37); clear_start = 1;
        tick();
        clear_start = 0;
        k = 0;
        do begin tick(); k++; end while (!o_gb && k < 600);
        chk("b_gnt_latency", k, WORDS + 1);
        chk("b_gnt_with_done", o_done, 1);
        b_req = 0;
        for (int i = 1; i <= 4; i++) a_op(0, i * 37, '0);
        tick();

        // Reset at sweep address 100
        clear_start = 1; tick(); clear_start = 0;
        k = 0;
        while (m_cnt != 100 && k < 600) begin tick(); k++; end
        chk("reached_100", k, 100);
        rst_n = 0; tick(); rst_n = 1;
        n = 0;
        for (int i = 0; i < WORDS + 2; i++) begin tick(); n += int'(o_busy); end
        chk("busy_after_midreset", n, WORDS);

        // clear_start during CLEAR is ignored
        clear_start = 1; tick(); clear_start = 0;
        repeat (10) tick();
        clear_start = 1; tick(); clear_start = 0;
        n = 0;
        for (int i = 0; i < WORDS + 10; i++) begin tick(); n += int'(o_done); end
        chk("done_count", n, 1);

        // Random traffic with occasional sweeps
        for (int i = 0; i < 400; i++) begin
            if (!a_req && $urandom_range(0, 1) == 1) begin
                a_req = 1; a_we = 1'($urandom_range(0, 1));
                a_addr = AW'($urandom_range(0, 15)); a_wdata = 16'($urandom);
            end
            if (!b_req && $urandom_range(0, 1) == 1) begin
                b_req = 1; b_we = 1'($urandom_range(0, 1));
                b_addr = AW'($urandom_range(0, 15)); b_wdata = 16'($urandom);
            end
            clear_start = ($urandom_range(0, 149) == 0);
            tick();
            if (g_ga) a_req = 0;
            if (g_gb) b_req = 0;
        end
        clear_start = 0; a_req = 0; b_req = 0;
        repeat (WORDS + 4) tick();
        for (int i = 0; i < 16; i++) a_op(0, i, '0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
